// File: rtl/dial_pkg.sv
// Shared definitions for the dial pipeline: ASCII byte codes seen by the
// parser, the parser state encoding, and the default distance width that the
// parser and the rotation stage agree on.
package dial_pkg;

  localparam int DIST_W_DEFAULT = 16;

  localparam logic [7:0] CHAR_L  = 8'h4C;
  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_9  = 8'h39;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGITS,
    ST_SKIP,
    ST_EMIT,
    ST_FINISHED
  } parse_state_e;

endpackage

// File: rtl/dec_accum.sv
// Saturating decimal accumulator: acc <= acc*10 + digit, clamped to all-ones.
// Latency: acc_next is combinational, acc register updates on the next edge.
// Backpressure: none; clr/load are qualified by the caller.
// Ports: clr zeroes acc; load folds in digit; acc_next is the value acc takes
// at the next edge; sat pulses when the current load clamps.
module dec_accum import dial_pkg::*; #(
  parameter int DIST_W = DIST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [3:0]        digit,
  output logic [DIST_W-1:0] acc_next,
  output logic              sat
);

  localparam int WW = DIST_W + 4;

  logic [DIST_W-1:0] acc_q, acc_d;
  logic [WW-1:0]     ext, prod;

  always_comb begin
    ext   = {4'b0000, acc_q};
    // x*10 as x*8 + x*2; four guard bits hold the worst case without wrap
    prod  = (ext << 3) + (ext << 1) + {{(WW-4){1'b0}}, digit};
    sat   = load && (prod[WW-1:DIST_W] != '0);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = sat ? '1 : prod[DIST_W-1:0];
    end
  end

  assign acc_next = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/move_parser.sv
// Parses an ASCII move stream (L68, R1000, ...) into {direction, distance} moves.
// Latency: terminator accepted at t -> move_valid at t+1; counters update one cycle later.
// Backpressure: in_ready drops for the whole emit phase until move_ready accepts the move.
// Ports: in_* byte stream (in_last marks end), move_* output handshake,
// moves_count/err_count saturating debug counters, overflow/done sticky flags.
module move_parser import dial_pkg::*; #(
  parameter int DIST_W = DIST_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              move_valid,
  output logic              move_direction,
  output logic [DIST_W-1:0] move_distance,
  input  logic              move_ready,
  output logic [CNT_W-1:0]  moves_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              overflow,
  output logic              done
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  parse_state_e      state_q, state_d;
  logic              line_dir_q, line_dir_d;   // direction of the line being parsed
  logic              dig_q, dig_d;             // at least one digit seen on this line
  logic              last_q, last_d;           // in_last already consumed, finish after emit
  logic              dir_q, dir_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [CNT_W-1:0]  moves_q, moves_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              byte_acc, is_digit, is_term, is_sep, is_dir;
  logic              acc_clr, acc_load, acc_sat, err_inc;
  logic [DIST_W-1:0] acc_next;

  dec_accum #(.DIST_W(DIST_W)) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .load     (acc_load),
    .digit    (in_data[3:0]),
    .acc_next (acc_next),
    .sat      (acc_sat)
  );

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DIGITS) || (state_q == ST_SKIP);

  always_comb begin
    state_d    = state_q;
    line_dir_d = line_dir_q;
    dig_d      = dig_q;
    last_d     = last_q;
    dir_d      = dir_q;
    dist_d     = dist_q;
    moves_d    = moves_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    acc_clr    = 1'b0;
    acc_load   = 1'b0;
    err_inc    = 1'b0;

    byte_acc = in_valid && in_ready;
    is_digit = (in_data >= CHAR_0) && (in_data <= CHAR_9);
    is_term  = (in_data == CHAR_CR) || (in_data == CHAR_LF);
    is_sep   = is_term || (in_data == CHAR_SP);
    is_dir   = (in_data == CHAR_L) || (in_data == CHAR_R);

    case (state_q)
      ST_IDLE: if (byte_acc) begin
        if (is_dir) begin
          line_dir_d = (in_data == CHAR_R);
          acc_clr    = 1'b1;
          dig_d      = 1'b0;
          // a direction letter as the final byte is a partial line
          err_inc    = in_last;
          state_d    = in_last ? ST_FINISHED : ST_DIGITS;
        end else if (is_sep) begin
          if (in_last) state_d = ST_FINISHED;
        end else begin
          err_inc = 1'b1;
          state_d = in_last ? ST_FINISHED : ST_SKIP;
        end
      end
      ST_DIGITS: if (byte_acc) begin
        if (is_digit) begin
          acc_load = 1'b1;
          dig_d    = 1'b1;
          if (in_last) begin
            state_d = ST_EMIT;
            last_d  = 1'b1;
          end
        end else if (is_term) begin
          if (dig_q) begin
            state_d = ST_EMIT;
            last_d  = in_last;
          end else begin
            err_inc = 1'b1;
            state_d = in_last ? ST_FINISHED : ST_IDLE;
          end
        end else begin
          err_inc = 1'b1;
          state_d = in_last ? ST_FINISHED : ST_SKIP;
        end
      end
      ST_SKIP: if (byte_acc) begin
        if (in_last)                  state_d = ST_FINISHED;
        else if (in_data == CHAR_LF)  state_d = ST_IDLE;
      end
      ST_EMIT: if (move_ready) begin
        moves_d = sat_inc(moves_q);
        state_d = last_q ? ST_FINISHED : ST_IDLE;
        last_d  = 1'b0;
      end
      ST_FINISHED: ;
      default: state_d = ST_IDLE;
    endcase

    // output registers change only on EMIT entry so downstream can sample late
    if ((state_d == ST_EMIT) && (state_q != ST_EMIT)) begin
      dir_d  = line_dir_q;
      dist_d = acc_next;
    end
    if (acc_sat) ovf_d = 1'b1;
    if (err_inc) err_d = sat_inc(err_q);
    done_d = done_q || (state_d == ST_FINISHED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      line_dir_q <= 1'b0;
      dig_q      <= 1'b0;
      last_q     <= 1'b0;
      dir_q      <= 1'b0;
      dist_q     <= '0;
      moves_q    <= '0;
      err_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_dir_q <= line_dir_d;
      dig_q      <= dig_d;
      last_q     <= last_d;
      dir_q      <= dir_d;
      dist_q     <= dist_d;
      moves_q    <= moves_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign move_valid     = (state_q == ST_EMIT);
  assign move_direction = dir_q;
  assign move_distance  = dist_q;
  assign moves_count    = moves_q;
  assign err_count      = err_q;
  assign overflow       = ovf_q;
  assign done           = done_q;

endmodule

// File: tb/tb_move_parser.sv
// Bench for move_parser: table of short streams, hand-written multi-cycle
// sequences (backpressure, end-of-stream, reset), and random streams scored
// against a token-level model of the move grammar.
module tb_move_parser;

  logic        clk, rst_n;
  logic        in_valid, in_last, in_ready;
  logic [7:0]  in_data;
  logic        move_valid, move_direction, move_ready;
  logic [15:0] move_distance, moves_count, err_count;
  logic        overflow, done;

  logic man_rdy, rand_rdy, rand_en;
  assign move_ready = rand_en ? rand_rdy : man_rdy;

  move_parser dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .move_valid(move_valid), .move_direction(move_direction), .move_distance(move_distance),
    .move_ready(move_ready), .moves_count(moves_count), .err_count(err_count),
    .overflow(overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- move monitor ----------------
  logic        got_dir[$];
  int          got_dist[$];
  logic        post_chk = 1'b0;
  logic        hold_dir;
  logic [15:0] hold_dist;

  always @(negedge clk) begin
    if (!rst_n) begin
      post_chk = 1'b0;
    end else begin
      if (post_chk) begin
        check("hold_dist_after_xfer", move_distance, hold_dist);
        check("hold_dir_after_xfer", move_direction, hold_dir);
        post_chk = 1'b0;
      end
      if (move_valid && move_ready) begin
        got_dir.push_back(move_direction);
        got_dist.push_back(int'(move_distance));
        hold_dir  = move_direction;
        hold_dist = move_distance;
        post_chk  = 1'b1;
      end
    end
  end

  initial begin
    rand_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      rand_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input logic [7:0] b, input logic last);
    int guard = 0;
    while (!in_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
    end else begin
      in_valid = 1'b1; in_data = b; in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_move_valid"}, move_valid, 0);
    check({tag, "_dir"}, move_direction, 0);
    check({tag, "_dist"}, move_distance, 0);
    check({tag, "_moves"}, moves_count, 0);
    check({tag, "_errs"}, err_count, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic do_reset(input bit chk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    man_rdy = 1'b1; rand_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (chk) check_reset_vals("reset");
    rst_n = 1'b1;
    got_dir.delete(); got_dist.delete();
  endtask

  // ---------------- reference model ----------------
  logic [7:0] strm[$];
  logic       exp_dir[$];
  int         exp_dist[$];
  int         exp_err;
  bit         exp_ovf;

  function automatic bit is_dig(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction
  function automatic bit is_eol(input logic [7:0] c);
    return c == 8'h0D || c == 8'h0A;
  endfunction

  // Reads the stream as tokens: separators, then a direction letter, a run of
  // digits, and a line terminator; anything else costs one error and the rest
  // of the line up to LF is thrown away.
  task automatic model();
    int i = 0;
    int n = strm.size();
    exp_dir.delete(); exp_dist.delete(); exp_err = 0; exp_ovf = 0;
    while (i < n) begin
      logic [7:0] c = strm[i];
      if (is_eol(c) || c == 8'h20) begin
        i++;
      end else if (c != "L" && c != "R") begin
        exp_err++;
        while (i < n && strm[i] != 8'h0A) i++;
        i++;
      end else begin
        logic   d = (c == "R");
        longint val = 0;
        int     nd = 0;
        i++;
        while (i < n && is_dig(strm[i])) begin
          val = val * 10 + longint'(strm[i] - 8'h30);
          if (val > 65535) begin val = 65535; exp_ovf = 1; end
          nd++; i++;
        end
        if (i >= n) begin
          if (nd > 0) begin exp_dir.push_back(d); exp_dist.push_back(int'(val)); end
          else exp_err++;
        end else if (is_eol(strm[i])) begin
          if (nd > 0) begin exp_dir.push_back(d); exp_dist.push_back(int'(val)); end
          else exp_err++;
          i++;
        end else begin
          exp_err++;
          while (i < n && strm[i] != 8'h0A) i++;
          i++;
        end
      end
    end
  endtask

  task automatic push_digits(input int nd);
    for (int j = 0; j < nd; j++) begin
      logic [7:0] dv = 8'($urandom_range(0, 9));
      strm.push_back(8'h30 + dv);
    end
  endtask

  task automatic push_term();
    if ($urandom_range(0, 1) != 0) strm.push_back(8'h0D);
    strm.push_back(8'h0A);
  endtask

  task automatic gen_stream(input int nlines);
    strm.delete();
    for (int l = 0; l < nlines; l++) begin
      int kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        for (int s = 0; s < int'($urandom_range(0, 2)); s++) strm.push_back(8'h20);
        strm.push_back($urandom_range(0, 1) != 0 ? 8'h52 : 8'h4C);
        push_digits($urandom_range(1, 6));
        push_term();
      end else if (kind == 6) begin
        strm.push_back(8'h58);
        push_digits($urandom_range(0, 3));
        strm.push_back(8'h0A);
      end else if (kind == 7) begin
        strm.push_back(8'h4C);
        push_term();
      end else if (kind == 8) begin
        strm.push_back(8'h52);
        push_digits($urandom_range(1, 3));
        strm.push_back(8'h20);
        strm.push_back(8'h0A);
      end else begin
        push_term();
      end
    end
    if ($urandom_range(0, 1) != 0) begin
      strm.push_back(8'h4C);
      push_digits($urandom_range(1, 3));
    end else begin
      strm.push_back(8'h0A);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [95:0] txt;
    int          len;
    int          nm;
    bit          fdir;
    int          fdist;
    bit          ldir;
    int          ldist;
    int          err;
    bit          ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"L68\nR48\n",   8, 2, 0, 68,    1, 48,    0, 0};
    vecs[1] = '{"L99999\n",     7, 1, 0, 65535, 0, 65535, 0, 1};
    vecs[2] = '{"X12\nL\nR5\n", 9, 1, 1, 5,     1, 5,     2, 0};
    vecs[3] = '{"  R0\r\n",     6, 1, 1, 0,     1, 0,     0, 0};
    vecs[4] = '{"L65535\n",     7, 1, 0, 65535, 0, 65535, 0, 0};
    vecs[5] = '{"L65536\n",     7, 1, 0, 65535, 0, 65535, 0, 1};
    vecs[6] = '{"R5 \nL2\n",    7, 1, 0, 2,     0, 2,     1, 0};
    vecs[7] = '{"R\r\n",        3, 0, 0, 0,     0, 0,     1, 0};
    vecs[8] = '{"L007\rR3\n",   8, 2, 0, 7,     1, 3,     0, 0};

    do_reset(1);

    for (int v = 0; v < 9; v++) begin
      do_reset(0);
      for (int k = 0; k < vecs[v].len; k++)
        send(vecs[v].txt[8*(vecs[v].len-1-k) +: 8], 1'b0);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_nmoves", v), got_dist.size(), vecs[v].nm);
      check($sformatf("vec%0d_moves_count", v), moves_count, vecs[v].nm);
      check($sformatf("vec%0d_err", v), err_count, vecs[v].err);
      check($sformatf("vec%0d_ovf", v), overflow, vecs[v].ovf);
      if (vecs[v].nm > 0 && got_dist.size() == vecs[v].nm) begin
        check($sformatf("vec%0d_first_dir", v), got_dir[0], vecs[v].fdir);
        check($sformatf("vec%0d_first_dist", v), got_dist[0], vecs[v].fdist);
        check($sformatf("vec%0d_last_dir", v), got_dir[vecs[v].nm-1], vecs[v].ldir);
        check($sformatf("vec%0d_last_dist", v), got_dist[vecs[v].nm-1], vecs[v].ldist);
      end
    end

    // R1000\r\n with downstream stalled for five cycles
    do_reset(0);
    man_rdy = 1'b0;
    send("R", 0); send("1", 0); send("0", 0); send("0", 0); send("0", 0); send(8'h0D, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_move_valid", move_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_dist", move_distance, 1000);
      check("stall_dir", move_direction, 1);
    end
    @(posedge clk); #1; man_rdy = 1'b1;
    @(posedge clk); #1; man_rdy = 1'b0;
    @(negedge clk);
    check("post_xfer_move_valid", move_valid, 0);
    check("post_xfer_in_ready", in_ready, 1);
    check("post_xfer_dist", move_distance, 1000);
    check("post_xfer_moves_count", moves_count, 1);
    man_rdy = 1'b1;
    send(8'h0A, 0);
    repeat (2) @(negedge clk);
    check("stall_nmoves", got_dist.size(), 1);
    check("stall_err", err_count, 0);

    // R7 with in_last on the final digit
    do_reset(0);
    send("R", 0); send("7", 1);
    @(negedge clk);
    check("last_emit_valid", move_valid, 1);
    check("last_done_early", done, 0);
    repeat (3) @(negedge clk);
    check("last_done", done, 1);
    check("last_in_ready", in_ready, 0);
    check("last_move_valid", move_valid, 0);
    check("last_moves_count", moves_count, 1);
    check("last_nmoves", got_dist.size(), 1);
    if (got_dist.size() == 1) begin
      check("last_dir", got_dir[0], 1);
      check("last_dist", got_dist[0], 7);
    end

    // reset mid-line, then reset while a move is pending
    do_reset(0);
    send("R", 0); send("1", 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_midline");
    @(posedge clk); #1; rst_n = 1'b1;
    send("L", 0); send("3", 0); send(8'h0A, 0);
    repeat (3) @(negedge clk);
    check("rst_midline_nmoves", got_dist.size(), 1);
    if (got_dist.size() == 1) begin
      check("rst_midline_dir", got_dir[0], 0);
      check("rst_midline_dist", got_dist[0], 3);
    end

    do_reset(0);
    man_rdy = 1'b0;
    send("R", 0); send("1", 0); send("2", 0); send(8'h0A, 0);
    @(negedge clk);
    check("rst_emit_pending", move_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_emit");
    @(posedge clk); #1; rst_n = 1'b1; man_rdy = 1'b1;
    send("L", 0); send("3", 0); send(8'h0A, 0);
    repeat (3) @(negedge clk);
    check("rst_emit_nmoves", got_dist.size(), 1);
    if (got_dist.size() == 1) begin
      check("rst_emit_dir", got_dir[0], 0);
      check("rst_emit_dist", got_dist[0], 3);
    end

    // random streams with random downstream backpressure
    for (int r = 0; r < 4; r++) begin
      int guard = 0;
      do_reset(0);
      gen_stream(25);
      model();
      rand_en = 1'b1;
      for (int k = 0; k < strm.size(); k++) send(strm[k], k == strm.size() - 1);
      while (!done && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      check($sformatf("rand%0d_done", r), done, 1);
      check($sformatf("rand%0d_nmoves", r), got_dist.size(), exp_dist.size());
      check($sformatf("rand%0d_moves_count", r), moves_count, exp_dist.size());
      check($sformatf("rand%0d_err", r), err_count, exp_err);
      check($sformatf("rand%0d_ovf", r), overflow, exp_ovf);
      for (int k = 0; k < exp_dist.size() && k < got_dist.size(); k++) begin
        check($sformatf("rand%0d_dir%0d", r, k), got_dir[k], exp_dir[k]);
        check($sformatf("rand%0d_dist%0d", r, k), got_dist[k], exp_dist[k]);
      end
      rand_en = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/move_parser.md
# move_parser

Upstream stage of the dial pipeline. Consumes the raw puzzle text as an ASCII byte stream (lines like `L68`, `R1000`) and produces one move per line on a valid/ready handshake to the dial rotation stage: direction bit plus 16-bit distance. Handles CR/LF/space separators, malformed lines, distance saturation and end-of-stream. Keeps move and error counters for debug.

## Interface
- DIST_W, 16, width of emitted distance and decimal accumulator
- CNT_W, 16, width of status counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  ASCII byte
- in_last  in  1  marks final byte of stream; qualified by in_valid
- in_ready  out  1  parser accepts in_data this cycle
- move_valid  out  1  move presented downstream
- move_direction  out  1  1 = R, 0 = L
- move_distance  out  DIST_W  decimal distance of the line
- move_ready  in  1  downstream accepts move
- moves_count  out  CNT_W  moves handed off
- err_count  out  CNT_W  malformed lines dropped
- overflow  out  1  sticky: some distance saturated
- done  out  1  sticky: in_last consumed and final move handed off

## Operation
- Byte accepted when in_valid && in_ready. Move transferred when move_valid && move_ready.
- States: IDLE, DIGITS, SKIP, EMIT, FINISHED.
- IDLE: `L`/`R` -> latch dir, clear acc and digit flag, go DIGITS. CR (0x0D), LF (0x0A), space -> stay. Any other byte -> err_count++, go SKIP.
- DIGITS: `0`-`9` -> acc = acc*10 + d, set digit flag. CR/LF -> if digit flag go EMIT, else err_count++ and go IDLE. Other byte -> err_count++, go SKIP.
- SKIP: discard until LF, then IDLE.
- EMIT: in_ready = 0; move_valid = 1; on transfer moves_count++, go IDLE (FINISHED if pending in_last).
- in_last on an accepted byte: if it completes a valid move (digit or terminator with digit flag set) go EMIT with done pending; else FINISHED (partial line without digits counts as error). FINISHED: in_ready = 0, move_valid = 0, done = 1; only reset leaves.
- Arithmetic: acc*10 + d computed at DIST_W+4 bits; result > 2^DIST_W−1 clamps to all-ones, sets overflow; further digits keep it clamped.
- move_direction/move_distance registers load only on entry to EMIT and hold until the next EMIT entry. Downstream samples them the cycle after handshake, so they must stay stable at least one cycle past transfer.
- Counters saturate at all-ones.
- Reset (any state, mid-line or mid-EMIT): everything returns to reset values, partial line and pending move discarded.

## Timing
- Reset values: in_ready 1, move_valid 0, move_direction 0, move_distance 0, moves_count 0, err_count 0, overflow 0, done 0; state IDLE.
- One byte per cycle max; in_ready combinational from state only (no in_valid dependency).
- Terminator accepted at cycle t -> move_valid = 1 at t+1; held until transfer; in_ready = 0 throughout EMIT, returns at the cycle after transfer.
- Minimum spacing between moves: 3 input bytes. move_ready may be low indefinitely; no data lost.
- moves_count updates the cycle after transfer; err_count the cycle after the offending byte.

## Structure
- Package dial_pkg: ASCII constants (CHAR_L, CHAR_R, CHAR_0, CHAR_9, CHAR_CR, CHAR_LF, CHAR_SP), parser state enum, DIST_W default shared with the rotation stage.
- Sub-module dec_accum: saturating acc*10+d with clear/load/overflow flag; the FSM and counters stay in move_parser.

## Test plan
- Stream `L68\nR48\n`, move_ready tied 1 -> moves (0,68) then (1,48); moves_count 2; err_count 0.
- `R1000\r\n` with move_ready low 5 cycles -> move_valid held, in_ready 0, distance 1000 stable through transfer and one cycle after.
- `L99999\n` -> move (0,65535), overflow 1.
- `X12\nL\nR5\n` -> err_count 2, single move (1,5).
- `R7` with in_last on `7` -> move (1,7), then done 1, in_ready 0.
- Reset asserted mid-`R12` and during EMIT -> all outputs at reset values, no move emitted; subsequent `L3\n` yields (0,3).
